loop_ctrl_pwm: RTL and testbench

LOOP_CTRL_PWM -- requirements
Module: loop_ctrl_pwm

---
 rtl/loop_ctrl_pkg.sv | 6 +
 rtl/loop_sync2.sv | 13 +
 rtl/loop_ctrl_pwm.sv | 94 +++++++++
 tb/tb_loop_ctrl_pwm.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/loop_ctrl_pkg.sv
// loop_ctrl_pkg: shared state encoding and parameter defaults for the loop controller
package loop_ctrl_pkg;
  localparam int CNT_W_DEF = 8;
  localparam int FAULT_N_DEF = 4;
  typedef enum logic [2:0] {IDLE, ON_BLANK, ON, OFF, FAULT} state_t;
endpackage

// File: rtl/loop_sync2.sv
// loop_sync2: two-flop synchroniser for an asynchronous level input
module loop_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk) begin
    if (rst) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
  end
endmodule

// File: rtl/loop_ctrl_pwm.sv
// loop_ctrl_pwm: fixed-period PWM drive with leading-edge blanking, cycle-by-cycle trip and fault latch
module loop_ctrl_pwm
  import loop_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int FAULT_N = FAULT_N_DEF
) (
  input  logic             CELCLK,
  input  logic             CELRST,
  input  logic             CELV,
  input  logic             CELG,
  input  logic             SUB,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  input  logic [3:0]       blank,
  input  logic             trip,
  output logic             drv,
  output logic             cyc_start,
  output logic             trip_flag,
  output logic             fault
);
  localparam int EW = $clog2(FAULT_N + 1);
  state_t state;
  logic [CNT_W-1:0] cnt, cnt_nx, sh_period, sh_duty, p_sh, d_sh, p_in, d_in, bl_sh, bl_in;
  logic [EW-1:0] early_cnt;
  logic early, trip_s, unused_pins;
  assign unused_pins = ^{CELV, CELG, SUB};
  loop_sync2 u_sync (.clk(CELCLK), .rst(CELRST), .d(trip), .q(trip_s));
  // live values decide the cycle being started, shadows govern the cycle in flight
  assign p_in = period < CNT_W'(2) ? CNT_W'(2) : period;
  assign d_in = duty > p_in - 1'b1 ? p_in - 1'b1 : duty;
  assign bl_in = CNT_W'(blank) < d_in ? CNT_W'(blank) : d_in;
  assign p_sh = sh_period < CNT_W'(2) ? CNT_W'(2) : sh_period;
  assign d_sh = sh_duty > p_sh - 1'b1 ? p_sh - 1'b1 : sh_duty;
  assign bl_sh = CNT_W'(blank) < d_sh ? CNT_W'(blank) : d_sh;
  assign cnt_nx = cnt + 1'b1;
  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      state <= IDLE;
      cnt <= '0;
      drv <= 1'b0;
      cyc_start <= 1'b0;
      trip_flag <= 1'b0;
      fault <= 1'b0;
      early_cnt <= '0;
      early <= 1'b0;
      sh_period <= '0;
      sh_duty <= '0;
    end else if (!en) begin
      state <= IDLE;
      cnt <= '0;
      drv <= 1'b0;
      cyc_start <= 1'b0;
      trip_flag <= 1'b0;
      fault <= 1'b0;
      early_cnt <= '0;
      early <= 1'b0;
    end else if (state != FAULT) begin
      if (state == IDLE || cnt == p_sh - 1'b1) begin
        state <= d_in == '0 ? OFF : (bl_in == '0 ? ON : ON_BLANK);
        cnt <= '0;
        drv <= d_in != '0;
        cyc_start <= 1'b1;
        trip_flag <= 1'b0;
        early <= 1'b0;
        sh_period <= period;
        sh_duty <= duty;
        if (state != IDLE && !early) early_cnt <= '0;
      end else begin
        cnt <= cnt_nx;
        cyc_start <= 1'b0;
        if (state == ON && trip_s) begin
          state <= OFF;
          drv <= 1'b0;
          trip_flag <= 1'b1;
          if (cnt == bl_sh) begin
            early <= 1'b1;
            early_cnt <= early_cnt + 1'b1;
            if (early_cnt == EW'(FAULT_N - 1)) begin
              state <= FAULT;
              fault <= 1'b1;
            end
          end
        end else if (state != OFF && cnt_nx == d_sh) begin
          state <= OFF;
          drv <= 1'b0;
        end else if (state == ON_BLANK && cnt_nx >= bl_sh) begin
          state <= ON;
        end
      end
    end
  end
endmodule

// File: tb/tb_loop_ctrl_pwm.sv
// tb_loop_ctrl_pwm: vector table plus scoreboarded corner sequences for loop_ctrl_pwm
module tb_loop_ctrl_pwm;
  logic CELCLK = 1'b0, CELRST = 1'b1, en = 1'b0, trip = 1'b0;
  logic CELV = 1'b1, CELG = 1'b0, SUB = 1'b0;
  logic [7:0] period = 8'd10, duty = 8'd4;
  logic [3:0] blank = 4'd2;
  logic drv, cyc_start, trip_flag, fault;
  int n_cmp = 0, n_err = 0;
  typedef struct { int p; int d; int b; int hi; int len; } vec_t;
  typedef struct { string nm; int hi; int len; int fall; int tf; } exp_t;
  exp_t sb[$];
  vec_t vt[10];

  always #5 CELCLK = ~CELCLK;

  loop_ctrl_pwm #(.CNT_W(8), .FAULT_N(4)) dut (
    .CELCLK(CELCLK), .CELRST(CELRST), .CELV(CELV), .CELG(CELG), .SUB(SUB),
    .en(en), .period(period), .duty(duty), .blank(blank), .trip(trip),
    .drv(drv), .cyc_start(cyc_start), .trip_flag(trip_flag), .fault(fault)
  );

  task automatic tick();
    @(posedge CELCLK);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_start();
    int n = 0;
    while (!cyc_start && n < 600) begin
      tick();
      n++;
    end
    if (!cyc_start) chk("start_timeout", int'(cyc_start), 1);
  endtask

  // measures one cycle from a cyc_start sample up to the next one; kind 1 bumps duty, kind 2 pulses trip
  task automatic run_cycle(input int act_at, input int kind, output int hi, output int len,
                           output int fall, output int tf);
    hi = 0; len = 0; fall = -1; tf = 0;
    wait_start();
    do begin
      if (drv) hi++;
      else if (fall < 0) fall = len;
      tf = int'(trip_flag);
      if (len == act_at && kind == 1) duty = 8'd6;
      if (len == act_at && kind == 2) trip = 1'b1;
      if (len == act_at + 1 && kind == 2) trip = 1'b0;
      len++;
      tick();
    end while (!cyc_start && len < 600);
    if (fall < 0) fall = len;
  endtask

  task automatic check_cycle(input int act_at, input int kind);
    int hi, len, fall, tf;
    exp_t e;
    run_cycle(act_at, kind, hi, len, fall, tf);
    e = sb.pop_front();
    chk({e.nm, ".hi"}, hi, e.hi);
    chk({e.nm, ".len"}, len, e.len);
    chk({e.nm, ".fall"}, fall, e.fall);
    chk({e.nm, ".tflag"}, tf, e.tf);
  endtask

  task automatic skip_cycle();
    int hi, len, fall, tf;
    run_cycle(-5, 0, hi, len, fall, tf);
  endtask

  task automatic set_cfg(input int p, input int d, input int b);
    period = 8'(p);
    duty = 8'(d);
    blank = 4'(b);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, n, sc;
    vt[0] = '{10, 4, 2, 4, 10};
    vt[1] = '{10, 15, 2, 9, 10};
    vt[2] = '{10, 0, 2, 0, 10};
    vt[3] = '{1, 1, 2, 1, 2};
    vt[4] = '{0, 5, 0, 1, 2};
    vt[5] = '{5, 3, 0, 3, 5};
    vt[6] = '{6, 2, 15, 2, 6};
    vt[7] = '{255, 254, 3, 254, 255};
    vt[8] = '{2, 2, 1, 1, 2};
    vt[9] = '{7, 7, 4, 6, 7};

    en = 1'b1; trip = 1'b1;
    repeat (3) tick();
    chk("rst.drv", drv, 0);
    chk("rst.cyc_start", cyc_start, 0);
    chk("rst.trip_flag", trip_flag, 0);
    chk("rst.fault", fault, 0);
    trip = 1'b0; CELRST = 1'b0;
    tick();
    chk("first.cyc_start", cyc_start, 1);
    chk("first.drv", drv, 1);
    sb.push_back('{"basic0", 4, 10, 4, 0});
    check_cycle(-5, 0);
    sb.push_back('{"basic1", 4, 10, 4, 0});
    check_cycle(-5, 0);

    for (int i = 0; i < 10; i++) begin
      set_cfg(vt[i].p, vt[i].d, vt[i].b);
      sb.push_back('{$sformatf("vec%0d", i), vt[i].hi, vt[i].len, vt[i].hi, 0});
      skip_cycle();
      check_cycle(-5, 0);
    end

    set_cfg(10, 8, 2);
    skip_cycle();
    sb.push_back('{"trip", 6, 10, 6, 1});
    check_cycle(3, 2);
    chk("trip.flag_clr", trip_flag, 0);
    sb.push_back('{"after_trip", 8, 10, 8, 0});
    check_cycle(-5, 0);

    set_cfg(10, 4, 2);
    skip_cycle();
    sb.push_back('{"duty_mid", 4, 10, 4, 0});
    check_cycle(2, 1);
    sb.push_back('{"duty_next", 6, 10, 6, 0});
    check_cycle(-5, 0);

    set_cfg(10, 8, 2);
    skip_cycle();
    trip = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{$sformatf("early_a%0d", i), 3, 10, 3, 1});
      check_cycle(-5, 0);
    end
    trip = 1'b0;
    sb.push_back('{"clean", 8, 10, 8, 0});
    check_cycle(-5, 0);
    trip = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{$sformatf("early_b%0d", i), 3, 10, 3, 1});
      check_cycle(-5, 0);
    end
    chk("early_reset.no_fault", fault, 0);
    hi = 0; n = 0;
    while (!fault && n < 50) begin
      if (drv) hi++;
      tick();
      n++;
    end
    chk("fault.set", fault, 1);
    chk("fault.last_pulse", hi, 3);
    chk("fault.drv", drv, 0);
    sc = 0; hi = 0;
    repeat (30) begin
      tick();
      if (cyc_start) sc++;
      if (drv) hi++;
    end
    chk("fault.no_start", sc, 0);
    chk("fault.drv_hold", hi, 0);
    chk("fault.hold", fault, 1);
    en = 1'b0; trip = 1'b0;
    tick();
    chk("fault.cleared", fault, 0);
    chk("idle.drv", drv, 0);
    en = 1'b1;
    set_cfg(10, 4, 2);
    tick();
    chk("restart.cyc_start", cyc_start, 1);

    tick(); tick();
    chk("rstmid.pre_drv", drv, 1);
    CELRST = 1'b1;
    tick();
    chk("rstmid.drv", drv, 0);
    chk("rstmid.cyc_start", cyc_start, 0);
    CELRST = 1'b0;
    tick();
    chk("rstmid.resume_start", cyc_start, 1);
    chk("rstmid.resume_drv", drv, 1);
    sb.push_back('{"rstmid.cycle", 4, 10, 4, 0});
    check_cycle(-5, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
